reg_native_arb: RTL and testbench

REG_NATIVE_ARB -- requirements
Module: reg_native_arb

---
 rtl/reg_native_arb_pkg.sv | 15 +
 rtl/reg_native_arb_if.sv | 48 ++++
 rtl/reg_native_rr_pick.sv | 33 +++
 rtl/reg_native_arb.sv | 157 +++++++++++++++
 tb/tb_reg_native_arb.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_native_arb_pkg.sv
// Shared types and helpers for the reg_native arbiter slice.
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Width of an index selecting one of n masters (at least one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/reg_native_arb_if.sv
// Bundled upstream-master and downstream reg_native signals of the arbiter.
interface reg_native_arb_if #(
  parameter int unsigned MST_NUM    = 2,
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [MST_NUM-1:0]                 mst__arb__req_vld;
  logic [MST_NUM-1:0][ADDR_WIDTH-1:0] mst__arb__addr;
  logic [MST_NUM-1:0]                 mst__arb__wr_en;
  logic [MST_NUM-1:0]                 mst__arb__rd_en;
  logic [MST_NUM-1:0][DATA_WIDTH-1:0] mst__arb__wr_data;
  logic [MST_NUM-1:0]                 mst__arb__soft_rst;

  logic [MST_NUM-1:0]                 arb__mst__ack_vld;
  logic [MST_NUM-1:0]                 arb__mst__err;
  logic [MST_NUM-1:0][DATA_WIDTH-1:0] arb__mst__rd_data;

  logic                               arb__downstream__req_vld;
  logic [ADDR_WIDTH-1:0]              arb__downstream__addr;
  logic                               arb__downstream__wr_en;
  logic                               arb__downstream__rd_en;
  logic [DATA_WIDTH-1:0]              arb__downstream__wr_data;
  logic                               arb__downstream__soft_rst;

  logic                               downstream__arb__ack_vld;
  logic                               downstream__arb__err;
  logic [DATA_WIDTH-1:0]              downstream__arb__rd_data;

  // Arbiter side.
  modport slave (
    input  mst__arb__req_vld, mst__arb__addr, mst__arb__wr_en, mst__arb__rd_en,
           mst__arb__wr_data, mst__arb__soft_rst,
           downstream__arb__ack_vld, downstream__arb__err, downstream__arb__rd_data,
    output arb__mst__ack_vld, arb__mst__err, arb__mst__rd_data,
           arb__downstream__req_vld, arb__downstream__addr, arb__downstream__wr_en,
           arb__downstream__rd_en, arb__downstream__wr_data, arb__downstream__soft_rst
  );

  // Environment side: the upstream masters plus the downstream target.
  modport master (
    output mst__arb__req_vld, mst__arb__addr, mst__arb__wr_en, mst__arb__rd_en,
           mst__arb__wr_data, mst__arb__soft_rst,
           downstream__arb__ack_vld, downstream__arb__err, downstream__arb__rd_data,
    input  arb__mst__ack_vld, arb__mst__err, arb__mst__rd_data,
           arb__downstream__req_vld, arb__downstream__addr, arb__downstream__wr_en,
           arb__downstream__rd_en, arb__downstream__wr_data, arb__downstream__soft_rst
  );
endinterface

// File: rtl/reg_native_rr_pick.sv
// Combinational round-robin picker: searches from the master after `last`.
module reg_native_rr_pick
  import reg_native_arb_pkg::*;
#(
  parameter int unsigned MST_NUM = 2,
  localparam int unsigned SELW   = sel_width(MST_NUM)
) (
  input  logic [MST_NUM-1:0] req,
  input  logic [SELW-1:0]    last,
  output logic [MST_NUM-1:0] gnt,
  output logic               vld
);

  int unsigned     idx;
  logic [SELW-1:0] sel;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    sel = '0;
    for (int unsigned k = 1; k <= MST_NUM; k++) begin
      idx = 32'(last) + k;
      if (idx >= MST_NUM) idx = idx - MST_NUM;
      sel = SELW'(idx);
      if (!vld && req[sel]) begin
        gnt[sel] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_native_arb.sv
// N-to-1 reg_native arbiter: per-master pending slot, round-robin grant,
// one outstanding downstream transaction with timeout-generated error.
module reg_native_arb
  import reg_native_arb_pkg::*;
#(
  parameter int unsigned MST_NUM        = 2,
  parameter int unsigned ADDR_WIDTH     = 48,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             reg_native_arb_clk,
  input  logic             reg_native_arb_rst,
  reg_native_arb_if.slave  bus,
  output logic             arb__viol
);

  localparam int unsigned SELW = sel_width(MST_NUM);
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;

  logic [MST_NUM-1:0]                 busy_q, pend_q;
  logic [MST_NUM-1:0][ADDR_WIDTH-1:0] slot_addr_q;
  logic [MST_NUM-1:0]                 slot_wr_q, slot_rd_q;
  logic [MST_NUM-1:0][DATA_WIDTH-1:0] slot_data_q;

  logic [SELW-1:0] last_q, gnt_q, pick_idx;
  logic [MST_NUM-1:0] pick_gnt;
  logic            pick_vld;
  logic [CNTW-1:0] cnt_q;

  logic [MST_NUM-1:0]                 ack_q, err_q;
  logic [MST_NUM-1:0][DATA_WIDTH-1:0] rd_q;
  logic                               viol_q;

  logic issue, ack_take, tmo, finish;

  reg_native_rr_pick #(.MST_NUM(MST_NUM)) u_pick (
    .req  (pend_q),
    .last (last_q),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < MST_NUM; i++)
      if (pick_gnt[i]) pick_idx = SELW'(i);
  end

  assign issue    = (state_q == ST_ISSUE);
  assign ack_take = (state_q == ST_WAIT) && bus.downstream__arb__ack_vld;
  // Ack takes priority over a timeout expiring in the same cycle.
  assign tmo      = (state_q == ST_WAIT) && !bus.downstream__arb__ack_vld && (cnt_q == CNT_LAST);
  assign finish   = ack_take || tmo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (finish) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge reg_native_arb_clk or posedge reg_native_arb_rst) begin
    if (reg_native_arb_rst) begin
      state_q <= ST_IDLE;
      last_q  <= SELW'(MST_NUM - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_vld) begin
        gnt_q  <= pick_idx;
        last_q <= pick_idx;
        cnt_q  <= '0;
      end else if (state_q == ST_WAIT && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Slots: busy spans load..completion, pending spans load..issue.
  always_ff @(posedge reg_native_arb_clk or posedge reg_native_arb_rst) begin
    if (reg_native_arb_rst) begin
      busy_q      <= '0;
      pend_q      <= '0;
      slot_addr_q <= '0;
      slot_wr_q   <= '0;
      slot_rd_q   <= '0;
      slot_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < MST_NUM; i++) begin
        if (bus.mst__arb__req_vld[i] && !busy_q[i]) begin
          busy_q[i]      <= 1'b1;
          pend_q[i]      <= 1'b1;
          slot_addr_q[i] <= bus.mst__arb__addr[i];
          slot_wr_q[i]   <= bus.mst__arb__wr_en[i];
          slot_rd_q[i]   <= bus.mst__arb__rd_en[i];
          slot_data_q[i] <= bus.mst__arb__wr_data[i];
        end else begin
          if (issue && gnt_q == SELW'(i)) pend_q[i] <= 1'b0;
          if (finish && gnt_q == SELW'(i)) busy_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge reg_native_arb_clk or posedge reg_native_arb_rst) begin
    if (reg_native_arb_rst) begin
      ack_q  <= '0;
      err_q  <= '0;
      rd_q   <= '0;
      viol_q <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      rd_q  <= '0;
      if (ack_take) begin
        ack_q[gnt_q] <= 1'b1;
        err_q[gnt_q] <= bus.downstream__arb__err;
        rd_q[gnt_q]  <= bus.downstream__arb__rd_data;
      end else if (tmo) begin
        ack_q[gnt_q] <= 1'b1;
        err_q[gnt_q] <= 1'b1;
      end
      viol_q <= (|(bus.mst__arb__req_vld & busy_q)) ||
                (bus.downstream__arb__ack_vld && state_q != ST_WAIT);
    end
  end

  always_comb begin
    bus.arb__downstream__req_vld = 1'b0;
    bus.arb__downstream__addr    = '0;
    bus.arb__downstream__wr_en   = 1'b0;
    bus.arb__downstream__rd_en   = 1'b0;
    bus.arb__downstream__wr_data = '0;
    if (issue) begin
      bus.arb__downstream__req_vld = 1'b1;
      bus.arb__downstream__addr    = slot_addr_q[gnt_q];
      bus.arb__downstream__wr_en   = slot_wr_q[gnt_q];
      bus.arb__downstream__rd_en   = slot_rd_q[gnt_q];
      bus.arb__downstream__wr_data = slot_data_q[gnt_q];
    end
  end

  assign bus.arb__downstream__soft_rst = |bus.mst__arb__soft_rst;
  assign bus.arb__mst__ack_vld         = ack_q;
  assign bus.arb__mst__err             = err_q;
  assign bus.arb__mst__rd_data         = rd_q;
  assign arb__viol                     = viol_q;

endmodule

// File: tb/tb_reg_native_arb.sv
// Self-checking bench for reg_native_arb: directed scenarios plus randomized
// traffic against a round-robin / latency reference model.
module tb_reg_native_arb;
  localparam int unsigned NM  = 2;
  localparam int unsigned AW  = 48;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic viol;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int          ds_req_seen = 0;
  int          viol_seen   = 0;
  int          mdl_last;

  reg_native_arb_if #(.MST_NUM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_native_arb #(
    .MST_NUM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .reg_native_arb_clk (clk),
    .reg_native_arb_rst (rst),
    .bus                (bus),
    .arb__viol          (viol)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.arb__downstream__req_vld === 1'b1) ds_req_seen++;
    if (viol === 1'b1) viol_seen++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    bus.mst__arb__req_vld = '0;
    bus.mst__arb__wr_en   = '0;
    bus.mst__arb__rd_en   = '0;
    bus.mst__arb__addr    = '0;
    bus.mst__arb__wr_data = '0;
  endtask

  task automatic set_req(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mst__arb__req_vld[m] = 1'b1;
    bus.mst__arb__wr_en[m]   = wr;
    bus.mst__arb__rd_en[m]   = !wr;
    bus.mst__arb__addr[m]    = a;
    bus.mst__arb__wr_data[m] = d;
  endtask

  task automatic set_ack(input logic v, input logic e, input logic [DW-1:0] d);
    bus.downstream__arb__ack_vld = v;
    bus.downstream__arb__err     = e;
    bus.downstream__arb__rd_data = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_req();
    set_ack(1'b0, 1'b0, '0);
    step();
    step();
    rst = 1'b0;
    step();
    mdl_last = NM - 1;
  endtask

  task automatic wait_ds(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.arb__downstream__req_vld === 1'b1) begin
        seen = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Caller sits in the issue cycle D; ack driven at D+delay, returns at D+delay+1.
  task automatic serve_ack(input int delay, input logic e, input logic [DW-1:0] d);
    for (int i = 0; i < delay; i++) step();
    set_ack(1'b1, e, d);
    step();
    set_ack(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr_req();
    bus.mst__arb__soft_rst = '0;
    set_ack(1'b0, 1'b0, '0);
    step();
    step();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b0 || bus.arb__downstream__addr !== '0 ||
        bus.arb__downstream__wr_en !== 1'b0 || bus.arb__downstream__rd_en !== 1'b0 ||
        bus.arb__downstream__wr_data !== '0)
      $display("FAIL reset_ds: got vld=%b addr=%0h required all zero",
               bus.arb__downstream__req_vld, bus.arb__downstream__addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.arb__mst__ack_vld !== '0 || bus.arb__mst__err !== '0 || bus.arb__mst__rd_data !== '0)
      $display("FAIL reset_mst: got ack=%b err=%b required 0", bus.arb__mst__ack_vld, bus.arb__mst__err);
    else pass_cnt++;
    total_cnt++;
    if (viol !== 1'b0) $display("FAIL reset_viol: got %b required 0", viol);
    else pass_cnt++;
    rst = 1'b0;
    step();
    step();
    mdl_last = NM - 1;
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b0 || viol !== 1'b0)
      $display("FAIL post_reset_idle: got req=%b viol=%b required 0 0", bus.arb__downstream__req_vld, viol);
    else pass_cnt++;
  endtask

  task automatic test_soft_rst;
    bus.mst__arb__soft_rst = 2'b10;
    #1;
    total_cnt++;
    if (bus.arb__downstream__soft_rst !== 1'b1)
      $display("FAIL soft_rst_or: got %b required 1", bus.arb__downstream__soft_rst);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b0 || viol !== 1'b0)
      $display("FAIL soft_rst_fsm: got req=%b viol=%b required 0 0", bus.arb__downstream__req_vld, viol);
    else pass_cnt++;
    bus.mst__arb__soft_rst = '0;
    #1;
    total_cnt++;
    if (bus.arb__downstream__soft_rst !== 1'b0)
      $display("FAIL soft_rst_clear: got %b required 0", bus.arb__downstream__soft_rst);
    else pass_cnt++;
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 48'h100, '0);
    step();
    clr_req();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b0)
      $display("FAIL read_latency_early: got req=%b required 0", bus.arb__downstream__req_vld);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b1 || bus.arb__downstream__addr !== 48'h100 ||
        bus.arb__downstream__rd_en !== 1'b1 || bus.arb__downstream__wr_en !== 1'b0)
      $display("FAIL read_issue: got vld=%b addr=%0h rd=%b wr=%b required 1 100 1 0",
               bus.arb__downstream__req_vld, bus.arb__downstream__addr,
               bus.arb__downstream__rd_en, bus.arb__downstream__wr_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b0 || bus.arb__downstream__addr !== '0)
      $display("FAIL read_issue_once: got vld=%b addr=%0h required 0 0",
               bus.arb__downstream__req_vld, bus.arb__downstream__addr);
    else pass_cnt++;
    step();
    step();
    set_ack(1'b1, 1'b0, 32'hDEADBEEF);
    step();
    set_ack(1'b0, 1'b0, '0);
    total_cnt++;
    if (bus.arb__mst__ack_vld !== 2'b01 || bus.arb__mst__err !== 2'b00)
      $display("FAIL read_ack: got ack=%b err=%b required 01 00", bus.arb__mst__ack_vld, bus.arb__mst__err);
    else pass_cnt++;
    total_cnt++;
    if (bus.arb__mst__rd_data[0] !== 32'hDEADBEEF || bus.arb__mst__rd_data[1] !== '0)
      $display("FAIL read_data: got m0=%0h m1=%0h required deadbeef 0",
               bus.arb__mst__rd_data[0], bus.arb__mst__rd_data[1]);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.arb__mst__ack_vld !== '0 || bus.arb__mst__rd_data !== '0)
      $display("FAIL read_ack_pulse: got ack=%b required 00", bus.arb__mst__ack_vld);
    else pass_cnt++;
    mdl_last = 0;
  endtask

  task automatic test_rotation;
    bit seen;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      set_req(0, 1'b0, 48'hA000 + 48'(rep), '0);
      set_req(1, 1'b1, 48'hB000 + 48'(rep), 32'h55);
      step();
      clr_req();
      for (int k = 0; k < 2; k++) begin
        wait_ds(8, seen);
        total_cnt++;
        if (!seen || bus.arb__downstream__addr !== ((k == 0 ? 48'hA000 : 48'hB000) + 48'(rep)))
          $display("FAIL rotation_order: rep=%0d slot=%0d got seen=%b addr=%0h required master %0d",
                   rep, k, seen, bus.arb__downstream__addr, k);
        else pass_cnt++;
        if (!seen) return;
        serve_ack(1, 1'b0, 32'(k));
        total_cnt++;
        if (bus.arb__mst__ack_vld !== NM'(1 << k))
          $display("FAIL rotation_ack: got %b required %b", bus.arb__mst__ack_vld, NM'(1 << k));
        else pass_cnt++;
      end
    end
    mdl_last = 1;
  endtask

  task automatic test_timeout;
    bit seen;
    int n;
    set_req(1, 1'b1, 48'h2000, 32'h12345678);
    step();
    clr_req();
    wait_ds(8, seen);
    total_cnt++;
    if (!seen || bus.arb__downstream__wr_en !== 1'b1 || bus.arb__downstream__wr_data !== 32'h12345678 ||
        bus.arb__downstream__addr !== 48'h2000)
      $display("FAIL timeout_issue: got seen=%b wr=%b data=%0h required 1 1 12345678",
               seen, bus.arb__downstream__wr_en, bus.arb__downstream__wr_data);
    else pass_cnt++;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n = i;
      if (bus.arb__mst__ack_vld !== '0) break;
    end
    total_cnt++;
    if (n !== TMO + 1) $display("FAIL timeout_latency: got %0d cycles required %0d", n, TMO + 1);
    else pass_cnt++;
    total_cnt++;
    if (bus.arb__mst__ack_vld !== 2'b10 || bus.arb__mst__err !== 2'b10 || bus.arb__mst__rd_data !== '0)
      $display("FAIL timeout_resp: got ack=%b err=%b required 10 10 data 0",
               bus.arb__mst__ack_vld, bus.arb__mst__err);
    else pass_cnt++;
    mdl_last = 1;
  endtask

  task automatic test_busy_drop;
    int r0, v0;
    step();
    r0 = ds_req_seen;
    v0 = viol_seen;
    set_req(0, 1'b0, 48'h300, '0);
    step();
    set_req(0, 1'b1, 48'h400, 32'h99);
    step();
    clr_req();
    total_cnt++;
    if (viol !== 1'b1 || bus.arb__downstream__req_vld !== 1'b1 || bus.arb__downstream__addr !== 48'h300)
      $display("FAIL busy_drop_issue: got viol=%b req=%b addr=%0h required 1 1 300",
               viol, bus.arb__downstream__req_vld, bus.arb__downstream__addr);
    else pass_cnt++;
    serve_ack(1, 1'b0, 32'h7);
    total_cnt++;
    if (bus.arb__mst__ack_vld !== 2'b01) $display("FAIL busy_drop_ack: got %b required 01", bus.arb__mst__ack_vld);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) step();
    total_cnt++;
    if (ds_req_seen - r0 !== 1) $display("FAIL busy_drop_reqs: got %0d required 1", ds_req_seen - r0);
    else pass_cnt++;
    total_cnt++;
    if (viol_seen - v0 !== 1) $display("FAIL busy_drop_viol: got %0d required 1", viol_seen - v0);
    else pass_cnt++;
    mdl_last = 0;
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    set_req(0, 1'b0, 48'h500, '0);
    step();
    clr_req();
    wait_ds(8, seen);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    set_ack(1'b1, 1'b0, 32'hCAFE);
    step();
    set_ack(1'b0, 1'b0, '0);
    total_cnt++;
    if (!seen || bus.arb__mst__ack_vld !== '0)
      $display("FAIL rst_wait_noack: got seen=%b ack=%b required 1 00", seen, bus.arb__mst__ack_vld);
    else pass_cnt++;
    total_cnt++;
    if (viol !== 1'b1) $display("FAIL rst_wait_viol: got %b required 1", viol);
    else pass_cnt++;
    set_req(1, 1'b0, 48'h600, '0);
    step();
    clr_req();
    step();
    total_cnt++;
    if (bus.arb__downstream__req_vld !== 1'b1 || bus.arb__downstream__addr !== 48'h600)
      $display("FAIL rst_wait_idle: got req=%b addr=%0h required 1 600",
               bus.arb__downstream__req_vld, bus.arb__downstream__addr);
    else pass_cnt++;
    serve_ack(2, 1'b1, 32'h1);
    total_cnt++;
    if (bus.arb__mst__ack_vld !== 2'b10 || bus.arb__mst__err !== 2'b10)
      $display("FAIL rst_wait_next: got ack=%b err=%b required 10 10", bus.arb__mst__ack_vld, bus.arb__mst__err);
    else pass_cnt++;
    mdl_last = 1;
  endtask

  task automatic test_random;
    logic [AW-1:0] e_addr[NM];
    logic          e_wr[NM];
    logic [DW-1:0] e_data[NM];
    bit            pend[NM];
    logic [NM-1:0][DW-1:0] exp_rd;
    bit seen, got;
    int j, n, delay, exp_n, v0;
    logic          r_err, exp_err;
    logic [DW-1:0] r_data;
    do_reset();
    v0 = viol_seen;
    for (int round = 0; round < 40; round++) begin
      int mask;
      mask = $urandom_range(1, (1 << NM) - 1);
      for (int m = 0; m < NM; m++) begin
        pend[m] = mask[m];
        if (mask[m]) begin
          e_wr[m]   = 1'($urandom_range(0, 1));
          e_addr[m] = {16'($urandom), $urandom};
          e_data[m] = e_wr[m] ? $urandom : '0;
          set_req(m, e_wr[m], e_addr[m], e_data[m]);
        end
      end
      step();
      clr_req();
      for (int g = 0; g < NM; g++) begin
        j = -1;
        for (int off = 1; off <= NM; off++)
          if (j < 0 && pend[(mdl_last + off) % NM]) j = (mdl_last + off) % NM;
        if (j < 0) break;
        wait_ds(8, seen);
        total_cnt++;
        if (!seen || bus.arb__downstream__addr !== e_addr[j] || bus.arb__downstream__wr_en !== e_wr[j] ||
            bus.arb__downstream__rd_en !== !e_wr[j] || bus.arb__downstream__wr_data !== e_data[j])
          $display("FAIL rand_issue: round=%0d got seen=%b addr=%0h wr=%b data=%0h required master %0d addr=%0h wr=%b data=%0h",
                   round, seen, bus.arb__downstream__addr, bus.arb__downstream__wr_en,
                   bus.arb__downstream__wr_data, j, e_addr[j], e_wr[j], e_data[j]);
        else pass_cnt++;
        if (!seen) return;
        pend[j]  = 1'b0;
        mdl_last = j;
        delay  = $urandom_range(1, TMO + 1);
        r_err  = 1'($urandom_range(0, 1));
        r_data = $urandom;
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= TMO + 2; i++) begin
          step();
          set_ack(1'b0, 1'b0, '0);
          if (bus.arb__mst__ack_vld !== '0) begin
            got = 1'b1;
            n = i;
            break;
          end
          if (i == delay && delay <= TMO) set_ack(1'b1, r_err, r_data);
        end
        exp_n   = (delay <= TMO) ? delay + 1 : TMO + 1;
        exp_err = (delay <= TMO) ? r_err : 1'b1;
        exp_rd  = '0;
        if (delay <= TMO) exp_rd[j] = r_data;
        total_cnt++;
        if (!got || n !== exp_n || bus.arb__mst__ack_vld !== NM'(1 << j) ||
            bus.arb__mst__err !== (exp_err ? NM'(1 << j) : NM'(0)) || bus.arb__mst__rd_data !== exp_rd)
          $display("FAIL rand_resp: round=%0d master=%0d got n=%0d ack=%b err=%b rd=%0h required n=%0d err=%b rd=%0h",
                   round, j, n, bus.arb__mst__ack_vld, bus.arb__mst__err, bus.arb__mst__rd_data,
                   exp_n, exp_err, exp_rd);
        else pass_cnt++;
      end
      for (int gap = $urandom_range(0, 2); gap > 0; gap--) step();
    end
    total_cnt++;
    if (viol_seen - v0 !== 0) $display("FAIL rand_viol: got %0d pulses required 0", viol_seen - v0);
    else pass_cnt++;
  endtask

  initial begin
    clr_req();
    bus.mst__arb__soft_rst = '0;
    set_ack(1'b0, 1'b0, '0);
    mdl_last = NM - 1;
    test_reset();
    test_soft_rst();
    test_single_read();
    test_rotation();
    test_timeout();
    test_busy_drop();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
